team_02_input_conditioner: RTL and testbench
============================================

# team_02_input_conditioner

Input front-end for the team_02 core: takes raw breakout-board GPIO inputs, synchronizes them to `clk`, debounces each channel with a runtime threshold, and produces clean levels, single-cycle edge pulses, and a queued edge-event stream.
- Sits between the top-level `gpio_in` pins and the team_02 core logic.
- The core consumes either the levels/pulses directly or the events through a valid/ready handshake.

## Interface
Parameters:
- `N_CH`, 8: number of input channels, 1..16
- `CNT_W`, 16: debounce counter width
- `FIFO_DEPTH`, 4: event queue entries, power of two, ≥2

Ports:
- `clk`  in  1: sole clock
- `nrst`  in  1: reset, asynchronous, active-low
- `en`  in  1: block enable; low freezes debounce and event generation
- `raw_in`  in  N_CH: asynchronous pin inputs
- `debounce_limit`  in  CNT_W: consecutive stable samples required; 0 treated as 1
- `level_out`  out  N_CH: debounced level
- `rise_pulse`  out  N_CH: one-cycle pulse on debounced 0→1
- `fall_pulse`  out  N_CH: one-cycle pulse on debounced 1→0
- `evt_valid`  out  1: event word available
- `evt_ready`  in  1: consumer pops when `evt_valid & evt_ready`
- `evt_data`  out  2*N_CH: `{rise_mask, fall_mask}` of one edge cycle
- `evt_overflow`  out  1: sticky, set when an event is dropped
- `clear_overflow`  in  1: clears `evt_overflow`

## Operation
- **Synchronizer:** 2-flop chain per channel; the output is `s[i]`. The chain runs regardless of `en`.
- **Debounce (per channel), when `en`=1:**
  - `s[i]==level[i]`: the counter resets to 0.
  - Otherwise the counter increments.
  - When counter+1 ≥ max(`debounce_limit`, 1): `level[i]` flips, the counter returns to 0, and the matching rise/fall pulse is registered high for exactly one cycle.
  - A change shorter than the limit never reaches `level_out`.
- **Limit changes:** a `debounce_limit` change takes effect immediately against the current count. If the new limit is at or below count+1, the flip happens on the next differing sample.
- **Events:** in any cycle where `rise_pulse|fall_pulse` is non-zero, the word `{rise_pulse, fall_pulse}` is pushed into the FIFO. Simultaneous edges on several channels form a single entry.
- **FIFO:**
  - `evt_data` always shows the head entry.
  - A push while full with no pop in the same cycle is dropped and sets `evt_overflow`.
  - A push while full with a pop in the same cycle is accepted.
  - A push while empty: the entry appears at the head the next cycle.
- **Overflow flag:** if a set and `clear_overflow` coincide, the set wins.
- **`en`=0:**
  - Counters are held at 0.
  - `level_out` is held.
  - Pulses are 0 and there are no pushes.
  - The FIFO still drains through the handshake.
- **Reset:** all flops are cleared.
  - `level_out`=0, pulses=0, `evt_valid`=0, `evt_data`=0, `evt_overflow`=0; FIFO is empty; sync flops are 0.
  - A pin held high through reset produces a rise event after release like any other edge.
  - Reset mid-operation discards queued events and in-progress counts.

## Timing
- `raw_in` is captured at edge E0 and `s` is valid after E0+1.
- With limit L, `level_out` and the pulse update at edge E0+1+L. L=1 gives a 2-cycle latency.
- `evt_valid` rises one cycle after the pulse cycle when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- `evt_valid` depends only on registered state; there is no combinational path from `evt_ready` to `evt_valid`.

## Configuration
- `TEAM_02_COND_SYNC3_EN`
  - **Defined:** the synchronizer is 3 flops and every latency above grows by 1 cycle (L=1 gives a 3-cycle latency).
  - **Undefined:** the synchronizer is 2 flops.

## Structure
- Package `team_02_cond_pkg`:
  - `evt_t` packed struct `{rise_mask, fall_mask}`
  - default parameter constants
  - `SYNC_STAGES` constant derived from the macro
- Sub-module `team_02_cond_channel`: synchronizer, counter, level and pulse for one channel; generated N_CH times.
- The FIFO and overflow logic are inline in the top module.

## Test plan
- **Clean edge:** L=4, set `raw_in[0]` 0→1 and hold → `level_out[0]`=1 at E0+5; `rise_pulse[0]` high for 1 cycle; `evt_data`=0x0100 (N_CH=8) with `evt_valid` one cycle later.
- **Glitch rejection:** L=4, pulse `raw_in[3]` high for 3 cycles → `level_out`, pulses and `evt_valid` stay 0.
- **Simultaneous edges:** L=1, channels 1 and 2 rise together while channel 0 (already high) falls → a single entry `{0x06, 0x01}`.
- **Overflow:** `evt_ready`=0, generate 5 edge cycles with depth 4 → 4 entries held and `evt_overflow`=1. Then push with a pop while full → no further drop. Then `clear_overflow` → flag 0.
- **Enable freeze:** `en`=0 while a pin toggles for 20 cycles → no level change or events, and queued events still drain. With `en`=1 and the pin now high → rise after L cycles.
- **Reset mid-count:** assert `nrst` low with 2 queued events and a partial count → all outputs 0. After release with the pin held high → a rise occurs at L+2 edges.

Source files
------------

// File: rtl/team_02_cond_pkg.sv
// team_02_cond_pkg: shared types and defaults; TEAM_02_COND_SYNC3_EN selects a 3-flop synchronizer.
package team_02_cond_pkg;
  localparam int MAX_CH = 16;
  localparam int DEF_N_CH = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_FIFO_DEPTH = 4;
`ifdef TEAM_02_COND_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif
  typedef struct packed {
    logic [MAX_CH-1:0] rise_mask;
    logic [MAX_CH-1:0] fall_mask;
  } evt_t;
endpackage

// File: rtl/team_02_cond_channel.sv
// team_02_cond_channel: one-channel synchronizer, debounce counter, level and edge pulses (depth via TEAM_02_COND_SYNC3_EN).
module team_02_cond_channel import team_02_cond_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             raw,
  input  logic [CNT_W-1:0] limit,
  output logic             level,
  output logic             rise,
  output logic             fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic [CNT_W:0] nxt;
  logic level_q, rise_q, fall_q, s, diff, hit;
  assign s = sync_q[SYNC_STAGES-1];
  assign lim = (limit == '0) ? CNT_W'(1) : limit;
  assign nxt = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign diff = s != level_q;
  // a lowered limit at or below count+1 flips on the very next differing sample
  assign hit = en & diff & (nxt >= {1'b0, lim});
  assign cnt_d = (!en || !diff || hit) ? '0 : nxt[CNT_W-1:0];
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q <= cnt_d;
      level_q <= level_q ^ hit;
      rise_q <= hit & s;
      fall_q <= hit & ~s;
    end
  assign level = level_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/team_02_input_conditioner.sv
// team_02_input_conditioner: GPIO sync/debounce with edge pulses and an edge-event FIFO (TEAM_02_COND_SYNC3_EN adds a sync stage).
module team_02_input_conditioner import team_02_cond_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [N_CH-1:0]   raw_in,
  input  logic [CNT_W-1:0]  debounce_limit,
  output logic [N_CH-1:0]   level_out,
  output logic [N_CH-1:0]   rise_pulse,
  output logic [N_CH-1:0]   fall_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2*N_CH-1:0] evt_data,
  output logic              evt_overflow,
  input  logic              clear_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [2*N_CH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic ovf_q, ovf_d, push, pop, full, empty, accept, drop;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    team_02_cond_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk), .nrst(nrst), .en(en), .raw(raw_in[i]), .limit(debounce_limit),
      .level(level_out[i]), .rise(rise_pulse[i]), .fall(fall_pulse[i])
    );
  end
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push = |{rise_pulse, fall_pulse};
  assign pop = evt_valid & evt_ready;
  // a full queue still takes a push when the head leaves in the same cycle
  assign accept = push & (!full | pop);
  assign drop = push & full & !pop;
  always_comb begin
    wr_d = accept ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
    ovf_d = drop | (ovf_q & ~clear_overflow);
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) mem_q[wr_q[AW-1:0]] <= {rise_pulse, fall_pulse};
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
    end
  assign evt_valid = !empty;
  assign evt_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign evt_overflow = ovf_q;
endmodule

// File: tb/tb_team_02_input_conditioner.sv
// tb_team_02_input_conditioner: randomized bench against a run-length debounce model and a queue-based event FIFO model.
module tb_team_02_input_conditioner;
  localparam int N_CH = 8;
  localparam int CNT_W = 16;
  localparam int D = 4;
  localparam int SS = team_02_cond_pkg::SYNC_STAGES;
  logic clk = 1'b0, nrst = 1'b0, en = 1'b0, evt_ready = 1'b0, clear_overflow = 1'b0;
  logic [N_CH-1:0] raw_in = '0;
  logic [CNT_W-1:0] debounce_limit = '0;
  logic [N_CH-1:0] level_out, rise_pulse, fall_pulse;
  logic evt_valid, evt_overflow;
  logic [2*N_CH-1:0] evt_data;
  int total = 0, bad = 0;
  team_02_input_conditioner #(.N_CH(N_CH), .CNT_W(CNT_W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .nrst(nrst), .en(en), .raw_in(raw_in), .debounce_limit(debounce_limit),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_overflow(evt_overflow), .clear_overflow(clear_overflow)
  );
  always #5 clk = ~clk;
  logic [N_CH-1:0] pipe [SS];
  int run [N_CH];
  logic [N_CH-1:0] m_lvl, m_rise, m_fall;
  logic [2*N_CH-1:0] q [$];
  bit m_ovf;
  always @(posedge clk or negedge nrst) begin : model
    logic [N_CH-1:0] s, nr, nf;
    int lm;
    bit popm, pushm, dropm;
    if (!nrst) begin
      for (int k = 0; k < SS; k++) pipe[k] = '0;
      for (int i = 0; i < N_CH; i++) run[i] = 0;
      m_lvl = '0; m_rise = '0; m_fall = '0; m_ovf = 0;
      q.delete();
    end else begin
      popm = q.size() != 0 && evt_ready;
      pushm = (m_rise | m_fall) != '0;
      dropm = pushm && q.size() == D && !popm;
      if (popm) void'(q.pop_front());
      if (pushm && !dropm) q.push_back({m_rise, m_fall});
      m_ovf = dropm ? 1'b1 : (clear_overflow ? 1'b0 : m_ovf);
      s = pipe[SS-1];
      lm = (debounce_limit == 0) ? 1 : int'(debounce_limit);
      nr = '0; nf = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (!en || s[i] == m_lvl[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] >= lm) begin
            m_lvl[i] = s[i];
            nr[i] = s[i];
            nf[i] = ~s[i];
            run[i] = 0;
          end
        end
      end
      m_rise = nr; m_fall = nf;
      for (int k = SS - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = raw_in;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare();
    chk("level", 32'(level_out), 32'(m_lvl));
    chk("rise", 32'(rise_pulse), 32'(m_rise));
    chk("fall", 32'(fall_pulse), 32'(m_fall));
    chk("valid", 32'(evt_valid), 32'(q.size() != 0));
    chk("data", 32'(evt_data), 32'(q.size() != 0 ? q[0] : '0));
    chk("ovf", 32'(evt_overflow), 32'(m_ovf));
  endtask
  task automatic cycles(input int n, input int flip_div, input int lim_max, input int en_div, input int rdy_div);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      compare();
      for (int i = 0; i < N_CH; i++) if ($urandom_range(0, flip_div - 1) == 0) raw_in[i] = ~raw_in[i];
      if ($urandom_range(0, 39) == 0) debounce_limit = CNT_W'($urandom_range(0, lim_max));
      en = en_div == 0 ? 1'b0 : ($urandom_range(0, en_div - 1) != 0);
      evt_ready = rdy_div == 0 ? 1'b0 : ($urandom_range(0, rdy_div - 1) == 0);
      clear_overflow = $urandom_range(0, 29) == 0;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    compare();
    nrst = 1'b1;
    en = 1'b1;
    debounce_limit = 16'd4;
    cycles(1500, 8, 5, 16, 2);
    cycles(200, 3, 1, 64, 0);
    cycles(100, 3, 2, 64, 1);
    cycles(60, 4, 3, 0, 1);
    cycles(300, 10, 6, 16, 2);
    cycles(40, 3, 1, 64, 0);
    @(negedge clk);
    nrst = 1'b0;
    raw_in = '1;
    repeat (2) begin
      @(negedge clk);
      compare();
    end
    nrst = 1'b1;
    en = 1'b1;
    debounce_limit = 16'd3;
    evt_ready = 1'b1;
    clear_overflow = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      compare();
    end
    cycles(800, 12, 8, 32, 2);
    cycles(300, 2, 0, 32, 3);
    @(negedge clk);
    compare();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
